// File: rtl/online_otf_converter_r4.sv
// Online-to-parallel converter for radix-4 signed-digit streams.
// Incoming digits arrive MSD first. The first DELTA beats are dropped
// to cover the adder's online delay. The following N digits are folded
// into a two's-complement integer using on-the-fly conversion. Two
// registers are kept: Q holds the prefix value and QM holds Q-1. Each
// step then picks one of them, shifts it left by 2 and appends a 2-bit
// digit, so no carry chain is needed.
module online_otf_converter_r4 #(
    parameter int N     = 8,
    parameter int DELTA = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         zi_valid,
    input  logic [2:0]   zi,
    output logic         zi_ready,
    output logic [2*N:0] result,
    output logic         result_valid,
    input  logic         result_ack,
    output logic         err,
    output logic         busy
);

    localparam int W  = 2 * N + 1;
    localparam int CW = $clog2(N + 1);
    localparam int SW = (DELTA > 0) ? $clog2(DELTA + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CONV, S_DONE} state_t;

    // With no online delay the skip phase is bypassed entirely
    localparam state_t ENTRY = (DELTA > 0) ? S_SKIP : S_CONV;

    state_t        r_state;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_qm;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_skip;
    logic          r_err;
    logic [W-1:0]  r_result;
    logic          r_rv;
    logic          r_ready;
    logic          r_busy;

    logic          w_beat;
    logic          w_illegal;
    logic [2:0]    w_z;
    logic          w_pos;
    logic [1:0]    w_qd;
    logic [1:0]    w_qmd;
    logic [W-1:0]  w_q_next;
    logic [W-1:0]  w_qm_next;

    assign w_beat    = zi_valid & r_ready;
    assign w_illegal = (zi == 3'b100);
    // The illegal code 100 is folded to digit zero
    assign w_z       = w_illegal ? 3'b000 : zi;
    assign w_pos     = ~w_z[2] & (w_z != 3'b000);

    // The low bits of 4+z equal z[1:0] for z<0, so Q always appends z[1:0].
    // For QM, both z-1 (z>0) and 3+z (z<=0) reduce to z[1:0]-1 mod 4.
    assign w_qd      = w_z[1:0];
    assign w_qmd     = w_z[1:0] - 2'd1;
    assign w_q_next  = w_z[2] ? {r_qm[W-3:0], w_qd}  : {r_q[W-3:0], w_qd};
    assign w_qm_next = w_pos  ? {r_q[W-3:0],  w_qmd} : {r_qm[W-3:0], w_qmd};

    // Control FSM plus datapath registers, with outputs registered alongside state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_qm     <= '1;
            r_cnt    <= '0;
            r_skip   <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_rv     <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (start && r_state != S_DONE) begin
            // A new start, or an abort from SKIP/CONV; a same-cycle digit is dropped
            r_state  <= ENTRY;
            r_q      <= '0;
            r_qm     <= '1;
            r_cnt    <= '0;
            r_skip   <= '0;
            r_err    <= 1'b0;
            r_rv     <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                S_SKIP: begin
                    if (w_beat) begin
                        r_skip <= r_skip + SW'(1);
                        if (int'(r_skip) == DELTA - 1)
                            r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (w_beat) begin
                        r_q   <= w_q_next;
                        r_qm  <= w_qm_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_illegal)
                            r_err <= 1'b1;
                        if (int'(r_cnt) == N - 1) begin
                            r_state  <= S_DONE;
                            r_result <= w_q_next;
                            r_rv     <= 1'b1;
                            r_ready  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        r_state <= S_IDLE;
                        r_rv    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign zi_ready     = r_ready;
    assign result       = r_result;
    assign result_valid = r_rv;
    assign err          = r_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_online_otf_converter_r4.sv
// Directed bench for online_otf_converter_r4 with N=4.
// Two instances are used, one with DELTA=0 and one with DELTA=2.
// The sel signal routes the shared stimulus to one of them and picks
// which instance's outputs are checked.
module tb_online_otf_converter_r4;

    logic       clk = 1'b0;
    logic       reset, start, zi_valid, result_ack, sel;
    logic [2:0] zi;

    logic       rdy0, rv0, err0, busy0, rdy2, rv2, err2, busy2;
    logic [8:0] res0, res2;
    logic       s_rdy, s_rv, s_err, s_busy;
    logic [8:0] s_res;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    online_otf_converter_r4 #(.N(4), .DELTA(0)) u_d0 (
        .clk(clk), .reset(reset), .start(start & ~sel), .zi_valid(zi_valid & ~sel),
        .zi(zi), .zi_ready(rdy0), .result(res0), .result_valid(rv0),
        .result_ack(result_ack & ~sel), .err(err0), .busy(busy0));

    online_otf_converter_r4 #(.N(4), .DELTA(2)) u_d2 (
        .clk(clk), .reset(reset), .start(start & sel), .zi_valid(zi_valid & sel),
        .zi(zi), .zi_ready(rdy2), .result(res2), .result_valid(rv2),
        .result_ack(result_ack & sel), .err(err2), .busy(busy2));

    assign s_rdy  = sel ? rdy2  : rdy0;
    assign s_rv   = sel ? rv2   : rv0;
    assign s_err  = sel ? err2  : err0;
    assign s_busy = sel ? busy2 : busy0;
    assign s_res  = sel ? res2  : res0;

    typedef struct {
        logic       d2;
        int         nd;
        logic [2:0] dig [6];
        logic [8:0] exp_res;
        logic       exp_err;
        logic       gap;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic d2, input int nd,
                                input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                                input logic [2:0] d, input logic [2:0] e, input logic [2:0] f,
                                input logic [8:0] r, input logic er, input logic g);
        vec_t v;
        v.d2 = d2; v.nd = nd;
        v.dig[0] = a; v.dig[1] = b; v.dig[2] = c;
        v.dig[3] = d; v.dig[4] = e; v.dig[5] = f;
        v.exp_res = r; v.exp_err = er; v.gap = g;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one whole conversion: start, digits (with optional gaps), result, ack
    task automatic run_vec(input vec_t v, input bit do_ack);
        sel = v.d2;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ready_after_start", {31'd0, s_rdy}, 32'd1);
        chk("err_cleared_by_start", {31'd0, s_err}, 32'd0);
        chk("busy_after_start", {31'd0, s_busy}, 32'd1);
        for (int i = 0; i < v.nd; i++) begin
            if (v.gap) begin
                zi_valid = 1'b0;
                zi = 3'b011;
                step();
            end
            chk("no_early_valid", {31'd0, s_rv}, 32'd0);
            zi_valid = 1'b1;
            zi = v.dig[i];
            step();
            zi_valid = 1'b0;
        end
        chk("result_valid", {31'd0, s_rv}, 32'd1);
        chk("result", {23'd0, s_res}, {23'd0, v.exp_res});
        chk("err", {31'd0, s_err}, {31'd0, v.exp_err});
        chk("ready_in_done", {31'd0, s_rdy}, 32'd0);
        if (do_ack) begin
            result_ack = 1'b1;
            step();
            result_ack = 1'b0;
            chk("valid_after_ack", {31'd0, s_rv}, 32'd0);
            chk("idle_after_ack", {31'd0, s_busy}, 32'd0);
            chk("result_retained", {23'd0, s_res}, {23'd0, v.exp_res});
            if (v.exp_err)
                chk("err_held_idle", {31'd0, s_err}, 32'd1);
        end
    endtask

    initial begin
        vecs[0] = mk(1'b0, 4, 3'b001, 3'b010, 3'b101, 3'b011, 3'b000, 3'b000, 9'd87,  1'b0, 1'b0);
        vecs[1] = mk(1'b0, 4, 3'b101, 3'b101, 3'b101, 3'b101, 3'b000, 3'b000, 9'h101, 1'b0, 1'b0);
        vecs[2] = mk(1'b0, 4, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 9'h1FF, 1'b0, 1'b1);
        vecs[3] = mk(1'b1, 6, 3'b011, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000, 9'd64,  1'b0, 1'b1);
        vecs[4] = mk(1'b0, 4, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 9'd64,  1'b1, 1'b0);
        vecs[5] = mk(1'b0, 4, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 9'h0FF, 1'b0, 1'b0);
        vecs[6] = mk(1'b1, 6, 3'b100, 3'b111, 3'b010, 3'b110, 3'b001, 3'b111, 9'd99,  1'b0, 1'b0);

        reset = 1'b1; start = 1'b0; zi_valid = 1'b0; zi = 3'b000;
        result_ack = 1'b0; sel = 1'b0;
        #3;
        chk("rst_valid0", {31'd0, rv0}, 32'd0);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_ready0", {31'd0, rdy0}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_result0", {23'd0, res0}, 32'd0);
        chk("rst_valid2", {31'd0, rv2}, 32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        chk("rst_result2", {23'd0, res2}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("idle_ready", {31'd0, rdy0}, 32'd0);

        for (int k = 0; k < 7; k++)
            run_vec(vecs[k], 1'b1);

        // DONE holds through missing ack, incoming digits and start pulses
        run_vec(vecs[0], 1'b0);
        for (int k = 0; k < 5; k++) begin
            zi_valid = 1'b1;
            zi = 3'b011;
            start = (k % 2 == 0);
            step();
            chk("hold_ready", {31'd0, s_rdy}, 32'd0);
            chk("hold_valid", {31'd0, s_rv}, 32'd1);
            chk("hold_result", {23'd0, s_res}, 32'd87);
        end
        zi_valid = 1'b0; start = 1'b0;
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("hold_ack_idle", {31'd0, s_busy}, 32'd0);
        chk("hold_ack_valid", {31'd0, s_rv}, 32'd0);
        chk("hold_ack_result", {23'd0, s_res}, 32'd87);

        // Ack outside DONE does nothing
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("stray_ack_busy", {31'd0, s_busy}, 32'd0);

        // Abort mid-conversion; the digit offered alongside start is dropped
        sel = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        zi_valid = 1'b1; zi = 3'b011; step();
        zi = 3'b011; step();
        start = 1'b1; zi = 3'b001; step();
        start = 1'b0;
        zi = 3'b000; step();
        zi = 3'b000; step();
        zi = 3'b000; step();
        chk("abort_no_valid", {31'd0, s_rv}, 32'd0);
        zi = 3'b001; step();
        zi_valid = 1'b0;
        chk("abort_valid", {31'd0, s_rv}, 32'd1);
        chk("abort_result", {23'd0, s_res}, 32'd1);
        result_ack = 1'b1; step(); result_ack = 1'b0;

        // Async reset partway through a conversion
        sel = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        zi_valid = 1'b1; zi = 3'b001; step();
        zi = 3'b010; step();
        zi_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, s_rv}, 32'd0);
        chk("mid_rst_busy", {31'd0, s_busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, s_rdy}, 32'd0);
        chk("mid_rst_result", {23'd0, s_res}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_no_valid", {31'd0, s_rv}, 32'd0);
        run_vec(mk(1'b0, 4, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 9'd2, 1'b0, 1'b0), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
